// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run-time controller for the programmable clock divider.
// Holds the active divisor, accepts new divisors via valid/ready and applies
// them only on period boundaries. Sequences start/stop and optional bursts.
// Optional feature macro: CLKDIV_CTRL_BURST_EN (fixed-length bursts).
module clkdiv_ctrl #(
  parameter int unsigned         CNT_W       = 28,
  parameter logic [CNT_W-1:0]    DEF_DIVISOR = 28'd50000000,
  parameter int unsigned         BURST_W     = 16
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_divisor,
  output logic               cfg_ready,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  output logic               clock_out,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_e;

  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clk_q, clk_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               boundary;
  logic               accept;
  logic [CNT_W-1:0]   cfg_clamped;

`ifdef CLKDIV_CTRL_BURST_EN
  logic [BURST_W-1:0] burst_n_q, burst_n_d;
  logic [BURST_W-1:0] per_q, per_d;
`else
  logic               unused_burst_len;
  assign unused_burst_len = ^burst_len;
`endif

  assign cfg_ready   = ~pend_vld_q;
  assign accept      = cfg_valid & ~pend_vld_q;
  assign cfg_clamped = (cfg_divisor < MIN_DIV) ? MIN_DIV : cfg_divisor;
  assign boundary    = (state_q != S_IDLE) && (cnt_q == div_q - CNT_W'(1));

  assign clock_out = clk_q;
  assign tick      = tick_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  // Next-state, counter, divisor update and registered-output precompute.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
`ifdef CLKDIV_CTRL_BURST_EN
    burst_n_d  = burst_n_q;
    per_d      = per_q;
`endif

    // Pending divisor takes over exactly at the period boundary.
    if (boundary && pend_vld_q) begin
      div_d      = pend_q;
      pend_vld_d = 1'b0;
    end

    if (accept) begin
      if (state_q == S_IDLE) begin
        div_d = cfg_clamped;
      end else begin
        pend_d     = cfg_clamped;
        pend_vld_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
`ifdef CLKDIV_CTRL_BURST_EN
          burst_n_d = burst_len;
          per_d     = '0;
`endif
        end
      end
      S_RUN: begin
        if (boundary) begin
          cnt_d = '0;
`ifdef CLKDIV_CTRL_BURST_EN
          per_d = per_q + BURST_W'(1);
          if (stop || ((burst_n_q != '0) && (per_q == burst_n_q - BURST_W'(1)))) begin
            state_d = S_IDLE;
          end
`else
          if (stop) begin
            state_d = S_IDLE;
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (stop) begin
            state_d = S_STOPPING;
          end
        end
      end
      S_STOPPING: begin
        if (boundary) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are computed from next-state values so they are flops that
    // line up with the counter value of the coming cycle.
    clk_d  = (state_d != S_IDLE) && (cnt_d < (div_d >> 1));
    tick_d = (state_d != S_IDLE) && (cnt_d == '0);
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= DEF_DIVISOR;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
    end
  end

`ifdef CLKDIV_CTRL_BURST_EN
  // Burst length capture and completed-period count.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      burst_n_q <= '0;
      per_q     <= '0;
    end else begin
      burst_n_q <= burst_n_d;
      per_q     <= per_d;
    end
  end
`endif

endmodule
